sram_1r1w_bypass_ext: RTL and testbench
=======================================

// Module: sram_1r1w_bypass_ext
// PURPOSE
//   Parametrised single-clock 1R1W SRAM macro with per-lane write mask and a registered read.
//   Adds write-first same-cycle bypass, a read-valid strobe, held read data and a collision counter.
//   Instantiated behind Chisel SyncReadMem wrappers (caches, shared mem, register banks).
//   Replaces fixed-geometry array_N_ext macros across all configs.
// PARAMETERS
//   DATA_WIDTH  256  word width in bits; must equal MASK_WIDTH*LANE_WIDTH
//   DEPTH       256  number of words; need not be a power of two
//   ADDR_WIDTH  8    address bits, >= clog2(DEPTH)
//   MASK_WIDTH  2    write-mask lanes; LANE_WIDTH = DATA_WIDTH/MASK_WIDTH
//   CNT_WIDTH   16   width of the collision counter
// PORTS
//   clock        in   1            single clock, all logic posedge
//   reset_n      in   1            synchronous reset, active-low
//   W0_addr      in   ADDR_WIDTH   write address
//   W0_en        in   1            write enable
//   W0_data      in   DATA_WIDTH   write data
//   W0_mask      in   MASK_WIDTH   bit i enables lane [i*LANE_WIDTH +: LANE_WIDTH]
//   R0_addr      in   ADDR_WIDTH   read address
//   R0_en        in   1            read enable
//   R0_data      out  DATA_WIDTH   read data, valid when R0_valid=1, held otherwise
//   R0_valid     out  1            read data returned this cycle
//   coll_cnt     out  CNT_WIDTH    saturating count of bypassed reads
// BEHAVIOUR
//   Reset (reset_n=0 at posedge):
//   - R0_valid=0, R0_data=0, coll_cnt=0, pipeline regs=0.
//   - Array contents are NOT reset.
//   - W0_en and R0_en are ignored in reset cycles: no write, no read launched.
//   - A read launched the cycle before reset asserts produces no R0_valid.
//   Write:
//   - W0_en=1 at posedge with W0_addr<DEPTH: lanes with W0_mask[i]=1 updated; other lanes keep value.
//   - W0_mask=0 is a legal no-op.
//   Read, latency 1 (base):
//   - R0_en=1 at cycle t -> R0_data = mem[R0_addr] at cycle t+1, with R0_valid=1 for exactly one cycle.
//   - Back-to-back reads give one result per cycle.
//   - R0_data is a register: it keeps the last returned value while R0_valid=0.
//   - Later writes to that address do not disturb R0_data until the next read completes.
//   Same-cycle collision (R0_en & W0_en & R0_addr==W0_addr, both < DEPTH):
//   - Write-first: lane i returns W0_data lane if W0_mask[i]=1, else the old array lane.
//   - coll_cnt increments by 1 and saturates at all-ones.
//   - A collision with W0_mask=0 still counts.
//   Out of range (addr >= DEPTH):
//   - Write is dropped.
//   - Read returns all-zero data with R0_valid=1.
//   - Never counted as a collision.
//   Read and write at different addresses in the same cycle are independent, with no stall.
// CONFIGURATION
//   SRAM_OUT_REG_EN defined:
//   - Adds an output register stage; read latency 2, R0_valid delayed to match.
//   - Bypass is resolved at stage 1.
//   - A write at cycle t+1 to the address read at t is NOT visible in that read's result.
//   - Reset clears both stages.
//   SRAM_OUT_REG_EN undefined: latency 1 as above.
//   coll_cnt behaviour is identical in both builds.
// TESTING
//   1 Reset, then write 0xA..A to addr 5 with mask=2'b11; read addr 5
//     -> R0_valid=1 one cycle later (two with OUT_REG), R0_data=0xA..A.
//   2 Write addr 7 = all-ones with mask=11; next cycle write all-zeros with mask=01; read 7
//     -> upper lane all-ones, lower lane 0.
//   3 Same cycle: write addr 3 = 0x5..5 with mask=10, read addr 3 (old 0xF..F)
//     -> upper lane 0x5..5, lower lane 0xF..F; coll_cnt=1.
//   4 Read addr 9, then idle 3 cycles while writing addr 9
//     -> R0_data holds the old value, R0_valid low, until the next read of 9 returns new data.
//   5 DEPTH=200: write addr 250, read addr 250 -> array unchanged, R0_data=0, R0_valid=1;
//     CNT_WIDTH=2, 5 collisions -> coll_cnt=3.
//   6 Assert reset_n=0 the cycle after R0_en=1 -> no R0_valid pulse;
//     R0_data=0, coll_cnt=0; array data survives reset.

Source files
------------

// File: rtl/sram_1r1w_bypass_ext.sv
// -----------------------------------------------------------------------------
// sram_1r1w_bypass_ext
//
// Single-clock 1R1W SRAM with a per-lane write mask and a registered read
// port. A read and a write to the same in-range address in the same cycle
// resolve write-first: masked-in lanes return the incoming write data, and the
// other lanes return the stored data. Each such collision bumps a saturating
// counter. Read data is held between reads, and R0_valid marks the cycle a
// result is returned. An address >= DEPTH drops the write and reads as zero.
//
// Build option:
//   SRAM_OUT_REG_EN  adds an output register stage. Read latency becomes 2.
//                    Bypass is still resolved in the first stage.
//
// Ports:
//   clock     in   single clock, all logic on posedge
//   reset_n   in   synchronous reset, active-low (array contents not reset)
//   W0_addr   in   write address
//   W0_en     in   write enable
//   W0_data   in   write data
//   W0_mask   in   lane write mask, bit i covers [i*LANE_WIDTH +: LANE_WIDTH]
//   R0_addr   in   read address
//   R0_en     in   read enable
//   R0_data   out  read data, updated when R0_valid=1, held otherwise
//   R0_valid  out  read result returned this cycle
//   coll_cnt  out  saturating count of bypassed (colliding) reads
// -----------------------------------------------------------------------------
module sram_1r1w_bypass_ext #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int MASK_WIDTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] W0_addr,
    input  logic                  W0_en,
    input  logic [DATA_WIDTH-1:0] W0_data,
    input  logic [MASK_WIDTH-1:0] W0_mask,
    input  logic [ADDR_WIDTH-1:0] R0_addr,
    input  logic                  R0_en,
    output logic [DATA_WIDTH-1:0] R0_data,
    output logic                  R0_valid,
    output logic [CNT_WIDTH-1:0]  coll_cnt
);

    localparam int LANE_WIDTH = DATA_WIDTH / MASK_WIDTH;
    localparam int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  collide;
    logic [IDX_WIDTH-1:0]  w_idx;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [CNT_WIDTH-1:0]  coll_cnt_q, coll_cnt_d;

    assign wr_in_range = ({1'b0, W0_addr} < DEPTH_LIM);
    assign rd_in_range = ({1'b0, R0_addr} < DEPTH_LIM);
    assign w_idx       = W0_addr[IDX_WIDTH-1:0];
    assign r_idx       = R0_addr[IDX_WIDTH-1:0];
    // Equal addresses imply the write side is in range too.
    assign collide     = R0_en && W0_en && rd_in_range && (R0_addr == W0_addr);

    // Storage: never reset; writes are suppressed while reset_n is low.
    always_ff @(posedge clock) begin
        if (reset_n && W0_en && wr_in_range) begin
            for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
                if (W0_mask[i]) begin
                    mem_q[w_idx][i*LANE_WIDTH +: LANE_WIDTH] <=
                        W0_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Write-first merge of the array word with the same-cycle write.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem_q[r_idx];
            if (collide) begin
                for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
                    if (W0_mask[i]) begin
                        rd_word[i*LANE_WIDTH +: LANE_WIDTH] =
                            W0_data[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        s1_valid_d = R0_en;
        s1_data_d  = R0_en ? rd_word : s1_data_q;
        coll_cnt_d = coll_cnt_q;
        if (collide && (coll_cnt_q != '1)) begin
            coll_cnt_d = coll_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            coll_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign coll_cnt = coll_cnt_q;

`ifdef SRAM_OUT_REG_EN
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;

    always_comb begin
        out_valid_d = s1_valid_q;
        out_data_d  = s1_valid_q ? s1_data_q : out_data_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Gating with reset_n cancels a result that is due in a reset cycle.
    assign R0_valid = out_valid_q & reset_n;
    assign R0_data  = out_data_q;
`else
    // Gating with reset_n cancels a result that is due in a reset cycle.
    assign R0_valid = s1_valid_q & reset_n;
    assign R0_data  = s1_data_q;
`endif

endmodule

// File: tb/tb_sram_1r1w_bypass_ext.sv
module tb_sram_1r1w_bypass_ext;

    localparam int DW    = 64;
    localparam int DEPTH = 200;
    localparam int AW    = 8;
    localparam int MW    = 2;
    localparam int CW    = 2;
    localparam int LW    = DW / MW;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;
`ifdef SRAM_OUT_REG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic [AW-1:0] W0_addr;
    logic          W0_en;
    logic [DW-1:0] W0_data;
    logic [MW-1:0] W0_mask;
    logic [AW-1:0] R0_addr;
    logic          R0_en;
    logic [DW-1:0] R0_data;
    logic          R0_valid;
    logic [CW-1:0] coll_cnt;

    always #5 clock = ~clock;

    sram_1r1w_bypass_ext #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .MASK_WIDTH(MW),
        .CNT_WIDTH (CW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .W0_addr (W0_addr),
        .W0_en   (W0_en),
        .W0_data (W0_data),
        .W0_mask (W0_mask),
        .R0_addr (R0_addr),
        .R0_en   (R0_en),
        .R0_data (R0_data),
        .R0_valid(R0_valid),
        .coll_cnt(coll_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: plain array plus a list of pending read results, each
    // tagged with the clock edge after which it becomes visible.
    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] mem_m [DEPTH];
    rd_t           pend[$];
    int unsigned   cyc = 0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data  = '0;
    int unsigned   exp_cnt   = 0;

    task automatic step(input logic rst_n, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                        input logic re, input logic [AW-1:0] ra);
        rd_t r;
        reset_n = rst_n;
        W0_en   = we;
        W0_addr = wa;
        W0_data = wd;
        W0_mask = wm;
        R0_en   = re;
        R0_addr = ra;
        @(posedge clock);
        cyc++;
        if (!rst_n) begin
            pend.delete();
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_cnt   = 0;
        end else begin
            if (re) begin
                r.due  = cyc + LAT - 1;
                r.data = '0;
                if (ra < DEPTH) begin
                    r.data = mem_m[ra];
                    if (we && wa == ra) begin
                        for (int i = 0; i < MW; i++)
                            if (wm[i]) r.data[i*LW +: LW] = wd[i*LW +: LW];
                        if (exp_cnt < CNT_MAX) exp_cnt++;
                    end
                end
                pend.push_back(r);
            end
            if (we && wa < DEPTH)
                for (int i = 0; i < MW; i++)
                    if (wm[i]) mem_m[wa][i*LW +: LW] = wd[i*LW +: LW];
            exp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_valid = 1'b1;
                exp_data  = pend[0].data;
                void'(pend.pop_front());
            end
        end
        #1;
    endtask

    task automatic nop();
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        step(1'b1, 1'b1, a, d, m, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, a);
    endtask

    task automatic drain();
        for (int unsigned i = 1; i < LAT; i++) nop();
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 8'd5, {$urandom, $urandom}, 2'b11, 1'b1, 8'd5);
        step(1'b0, 1'b1, 8'd5, {$urandom, $urandom}, 2'b11, 1'b1, 8'd5);
        checks++;
        if (R0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", R0_valid); end
        checks++;
        if (R0_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", R0_data); end
        checks++;
        if (coll_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", coll_cnt); end
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), {$urandom, $urandom}, 2'b11);
    endtask

    task automatic test_basic_rw();
        logic [DW-1:0] pat;
        pat = {16{4'hA}};
        wr(8'd5, pat, 2'b11);
        rd(8'd5);
        drain();
        checks++;
        if (R0_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", R0_valid); end
        checks++;
        if (R0_data !== pat) begin errors++; $display("FAIL basic_data: got %h want %h", R0_data, pat); end
        nop();
        checks++;
        if (R0_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b want 0", R0_valid); end
    endtask

    task automatic test_mask();
        logic [DW-1:0] want;
        want = {{LW{1'b1}}, {LW{1'b0}}};
        wr(8'd7, '1, 2'b11);
        wr(8'd7, '0, 2'b01);
        rd(8'd7);
        drain();
        checks++;
        if (R0_data !== want) begin errors++; $display("FAIL mask_data: got %h want %h", R0_data, want); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] want;
        want = {{8{4'h5}}, {8{4'hF}}};
        wr(8'd3, '1, 2'b11);
        step(1'b1, 1'b1, 8'd3, {16{4'h5}}, 2'b10, 1'b1, 8'd3);
        drain();
        checks++;
        if (R0_data !== want) begin errors++; $display("FAIL coll_data: got %h want %h", R0_data, want); end
        checks++;
        if (coll_cnt !== 2'd1) begin errors++; $display("FAIL coll_cnt: got %0d want 1", coll_cnt); end
    endtask

    task automatic test_hold();
        logic [DW-1:0] oldv;
        logic [DW-1:0] newv;
        oldv = {$urandom, $urandom};
        newv = ~oldv;
        wr(8'd9, oldv, 2'b11);
        rd(8'd9);
        drain();
        checks++;
        if (R0_data !== oldv) begin errors++; $display("FAIL hold_first: got %h want %h", R0_data, oldv); end
        for (int k = 0; k < 3; k++) begin
            wr(8'd9, newv, 2'b11);
            checks++;
            if (R0_valid !== 1'b0 || R0_data !== oldv) begin
                errors++;
                $display("FAIL hold_idle%0d: got v=%b d=%h want v=0 d=%h", k, R0_valid, R0_data, oldv);
            end
        end
        rd(8'd9);
        drain();
        checks++;
        if (R0_valid !== 1'b1 || R0_data !== newv) begin
            errors++;
            $display("FAIL hold_next: got v=%b d=%h want v=1 d=%h", R0_valid, R0_data, newv);
        end
    endtask

    task automatic test_out_of_range_and_sat();
        wr(8'd250, {$urandom, $urandom}, 2'b11);
        rd(8'd122);
        drain();
        checks++;
        if (R0_data !== mem_m[122]) begin errors++; $display("FAIL oor_alias: got %h want %h", R0_data, mem_m[122]); end
        rd(8'd250);
        drain();
        checks++;
        if (R0_valid !== 1'b1 || R0_data !== '0) begin
            errors++;
            $display("FAIL oor_read: got v=%b d=%h want v=1 d=0", R0_valid, R0_data);
        end
        step(1'b1, 1'b1, 8'd250, '1, 2'b11, 1'b1, 8'd250);
        drain();
        checks++;
        if (coll_cnt !== 2'd1 || R0_data !== '0) begin
            errors++;
            $display("FAIL oor_coll: got cnt=%0d d=%h want cnt=1 d=0", coll_cnt, R0_data);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 8'd11, {$urandom, $urandom}, MW'(k), 1'b1, 8'd11);
            checks++;
            if (coll_cnt !== CW'(exp_cnt)) begin
                errors++;
                $display("FAIL sat_step%0d: got %0d want %0d", k, coll_cnt, exp_cnt);
            end
        end
        checks++;
        if (coll_cnt !== 2'd3) begin errors++; $display("FAIL sat_final: got %0d want 3", coll_cnt); end
    endtask

    task automatic test_random();
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        for (int n = 0; n < 300; n++) begin
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 7));
            step(1'b1, 1'($urandom), wa, {$urandom, $urandom}, MW'($urandom), 1'($urandom), ra);
            checks++;
            if (R0_valid !== exp_valid || R0_data !== exp_data || coll_cnt !== CW'(exp_cnt)) begin
                errors++;
                $display("FAIL rand%0d: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         n, R0_valid, R0_data, coll_cnt, exp_valid, exp_data, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_cancel();
        logic [DW-1:0] keep;
        drain();
        keep = mem_m[40];
        rd(8'd40);
        reset_n = 1'b0;
        #1;
        checks++;
        if (R0_valid !== 1'b0) begin errors++; $display("FAIL rst_cancel_window: got %b want 0", R0_valid); end
        step(1'b0, 1'b1, 8'd40, ~keep, 2'b11, 1'b1, 8'd40);
        checks++;
        if (R0_valid !== 1'b0 || R0_data !== '0 || coll_cnt !== '0) begin
            errors++;
            $display("FAIL rst_cancel: got v=%b d=%h c=%0d want 0/0/0", R0_valid, R0_data, coll_cnt);
        end
        for (int unsigned i = 0; i < LAT; i++) begin
            nop();
            checks++;
            if (R0_valid !== 1'b0) begin errors++; $display("FAIL rst_no_pulse%0d: got %b want 0", i, R0_valid); end
        end
        rd(8'd40);
        drain();
        checks++;
        if (R0_valid !== 1'b1 || R0_data !== keep) begin
            errors++;
            $display("FAIL rst_survive: got v=%b d=%h want v=1 d=%h", R0_valid, R0_data, keep);
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_mask();
        test_collision();
        test_hold();
        test_out_of_range_and_sat();
        test_random();
        test_reset_cancel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
